// File: rtl/dircc_system_states_pkg.sv
// FSM state encodings shared by dircc thread-level controllers.
// rx_ctrl_state_t sequences dircc_receive_controller.
package dircc_system_states_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_READ      = 3'd1,
    RX_DISPATCH  = 3'd2,
    RX_WAIT      = 3'd3,
    RX_WRITEBACK = 3'd4
  } rx_ctrl_state_t;

endpackage

// File: rtl/dircc_types_pkg.sv
// Shared dircc payload and device-state types.
// Used by the receive path, the handlers and the state RAM.
package dircc_types_pkg;

  typedef struct packed {
    logic [7:0]  src_device;
    logic [7:0]  msg_type;
    logic [15:0] payload;
  } packet_data_t;

  typedef struct packed {
    logic [15:0] rx_seen;
    logic [15:0] user_state;
  } device_state_t;

endpackage

// File: rtl/dircc_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports: clk_i, rst_ni (async low), inc_i, count_o.
module dircc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dircc_receive_controller.sv
// One-at-a-time receive sequencer: accept packet, read device state,
// pulse the handler, optionally write state back. Ports: packet
// stream in (pkt_*), state RAM (st_*), handler (hdl_*), status.
module dircc_receive_controller
  import dircc_types_pkg::*;
  import dircc_system_states_pkg::*;
#(
  parameter int DEVICE_COUNT   = 4,
  parameter int DEV_ADDR_WIDTH =
    (DEVICE_COUNT > 1) ? $clog2(DEVICE_COUNT) : 1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pkt_valid,
  output logic                      pkt_ready,
  input  packet_data_t              pkt_data,
  input  logic [7:0]                pkt_dst_device,
  input  logic [7:0]                pkt_edge_id,
  input  logic [7:0]                pkt_port_id,
  output logic                      st_rd_en,
  output logic [DEV_ADDR_WIDTH-1:0] st_rd_addr,
  input  device_state_t             st_rd_data,
  output logic                      st_wr_en,
  output logic [DEV_ADDR_WIDTH-1:0] st_wr_addr,
  output device_state_t             st_wr_data,
  output packet_data_t              hdl_packet,
  output logic                      hdl_packet_valid,
  output logic                      hdl_receive_done,
  output logic [7:0]                hdl_edge_id,
  output logic [7:0]                hdl_port_id,
  output device_state_t             hdl_read_state,
  input  logic                      hdl_packet_handled,
  input  device_state_t             hdl_write_state,
  input  logic                      hdl_write_state_valid,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [COUNT_WIDTH-1:0]    rx_count,
  output logic [COUNT_WIDTH-1:0]    drop_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [8:0] DEV_LIMIT = 9'(DEVICE_COUNT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  rx_ctrl_state_t state_q, state_d;
  logic pkt_ready_q, pkt_ready_d;
  logic st_rd_en_q, st_rd_en_d;
  logic [DEV_ADDR_WIDTH-1:0] st_rd_addr_q, st_rd_addr_d;
  logic st_wr_en_q, st_wr_en_d;
  logic [DEV_ADDR_WIDTH-1:0] st_wr_addr_q, st_wr_addr_d;
  device_state_t st_wr_data_q, st_wr_data_d;
  packet_data_t hdl_packet_q, hdl_packet_d;
  logic hdl_valid_q, hdl_valid_d;
  logic hdl_done_q, hdl_done_d;
  logic [7:0] hdl_edge_q, hdl_edge_d;
  logic [7:0] hdl_port_q, hdl_port_d;
  device_state_t hdl_rstate_q, hdl_rstate_d;
  logic busy_q, busy_d;
  logic timeout_q, timeout_d;
  logic [TW-1:0] timer_q, timer_d;
  logic wb_pend_q, wb_pend_d;
  device_state_t wb_state_q, wb_state_d;
  logic rx_inc, drop_inc;
  logic dst_bad;

  assign dst_bad = ({1'b0, pkt_dst_device} >= DEV_LIMIT);

  always_comb begin
    state_d      = state_q;
    pkt_ready_d  = pkt_ready_q;
    st_rd_en_d   = st_rd_en_q;
    st_rd_addr_d = st_rd_addr_q;
    st_wr_en_d   = st_wr_en_q;
    st_wr_addr_d = st_wr_addr_q;
    st_wr_data_d = st_wr_data_q;
    hdl_packet_d = hdl_packet_q;
    hdl_valid_d  = hdl_valid_q;
    hdl_done_d   = hdl_done_q;
    hdl_edge_d   = hdl_edge_q;
    hdl_port_d   = hdl_port_q;
    hdl_rstate_d = hdl_rstate_q;
    timeout_d    = timeout_q;
    timer_d      = timer_q;
    wb_pend_d    = wb_pend_q;
    wb_state_d   = wb_state_q;
    rx_inc       = 1'b0;
    drop_inc     = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (pkt_valid && pkt_ready_q) begin
          hdl_packet_d = pkt_data;
          hdl_edge_d   = pkt_edge_id;
          hdl_port_d   = pkt_port_id;
          if (dst_bad) begin
            drop_inc = 1'b1;
          end else begin
            st_rd_en_d   = 1'b1;
            st_rd_addr_d = pkt_dst_device[DEV_ADDR_WIDTH-1:0];
            pkt_ready_d  = 1'b0;
            state_d      = RX_READ;
          end
        end
      end
      RX_READ: begin
        // First READ cycle is the RAM access; data lands on the next.
        st_rd_en_d = 1'b0;
        if (!st_rd_en_q) begin
          hdl_rstate_d = st_rd_data;
          hdl_valid_d  = 1'b1;
          hdl_done_d   = 1'b1;
          state_d      = RX_DISPATCH;
        end
      end
      RX_DISPATCH: begin
        hdl_done_d = 1'b0;
        timer_d    = '0;
        wb_pend_d  = 1'b0;
        state_d    = RX_WAIT;
      end
      RX_WAIT: begin
        if (hdl_write_state_valid) begin
          wb_pend_d  = 1'b1;
          wb_state_d = hdl_write_state;
        end
        if (hdl_packet_handled) begin
          rx_inc = 1'b1;
          if (hdl_write_state_valid || wb_pend_q) begin
            st_wr_en_d   = 1'b1;
            st_wr_addr_d = st_rd_addr_q;
            st_wr_data_d = hdl_write_state_valid ?
                           hdl_write_state : wb_state_q;
            state_d      = RX_WRITEBACK;
          end else begin
            hdl_valid_d = 1'b0;
            pkt_ready_d = 1'b1;
            state_d     = RX_IDLE;
          end
        end else if (timer_q == T_LAST) begin
          timeout_d   = 1'b1;
          drop_inc    = 1'b1;
          wb_pend_d   = 1'b0;
          hdl_valid_d = 1'b0;
          pkt_ready_d = 1'b1;
          state_d     = RX_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RX_WRITEBACK: begin
        st_wr_en_d  = 1'b0;
        hdl_valid_d = 1'b0;
        pkt_ready_d = 1'b1;
        state_d     = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RX_IDLE;
      pkt_ready_q  <= 1'b1;
      st_rd_en_q   <= 1'b0;
      st_rd_addr_q <= '0;
      st_wr_en_q   <= 1'b0;
      st_wr_addr_q <= '0;
      st_wr_data_q <= '0;
      hdl_packet_q <= '0;
      hdl_valid_q  <= 1'b0;
      hdl_done_q   <= 1'b0;
      hdl_edge_q   <= '0;
      hdl_port_q   <= '0;
      hdl_rstate_q <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timer_q      <= '0;
      wb_pend_q    <= 1'b0;
      wb_state_q   <= '0;
    end else begin
      state_q      <= state_d;
      pkt_ready_q  <= pkt_ready_d;
      st_rd_en_q   <= st_rd_en_d;
      st_rd_addr_q <= st_rd_addr_d;
      st_wr_en_q   <= st_wr_en_d;
      st_wr_addr_q <= st_wr_addr_d;
      st_wr_data_q <= st_wr_data_d;
      hdl_packet_q <= hdl_packet_d;
      hdl_valid_q  <= hdl_valid_d;
      hdl_done_q   <= hdl_done_d;
      hdl_edge_q   <= hdl_edge_d;
      hdl_port_q   <= hdl_port_d;
      hdl_rstate_q <= hdl_rstate_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      timer_q      <= timer_d;
      wb_pend_q    <= wb_pend_d;
      wb_state_q   <= wb_state_d;
    end
  end

  dircc_sat_counter #(.WIDTH(COUNT_WIDTH)) u_rx_cnt (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .inc_i   (rx_inc),
    .count_o (rx_count)
  );

  dircc_sat_counter #(.WIDTH(COUNT_WIDTH)) u_drop_cnt (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .inc_i   (drop_inc),
    .count_o (drop_count)
  );

  assign pkt_ready        = pkt_ready_q;
  assign st_rd_en         = st_rd_en_q;
  assign st_rd_addr       = st_rd_addr_q;
  assign st_wr_en         = st_wr_en_q;
  assign st_wr_addr       = st_wr_addr_q;
  assign st_wr_data       = st_wr_data_q;
  assign hdl_packet       = hdl_packet_q;
  assign hdl_packet_valid = hdl_valid_q;
  assign hdl_receive_done = hdl_done_q;
  assign hdl_edge_id      = hdl_edge_q;
  assign hdl_port_id      = hdl_port_q;
  assign hdl_read_state   = hdl_rstate_q;
  assign busy             = busy_q;
  assign timeout_err      = timeout_q;

endmodule
